// File: rtl/mem_stage_forward_source.sv
// mem_stage_forward_source: MEM-stage register, data-memory controller and producer of the
// MEM/WB forwarding triples. Optional macro LOAD_EARLY_FORWARD_EN forwards load data from MEM in the rvalid cycle.
module mem_stage_forward_source #(
   parameter int WORD       = 32,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  ex_valid_i,
   output logic                  ex_ready_o,
   input  logic [WORD-1:0]       alu_result_i,
   input  logic [WORD-1:0]       reg_2_data_i,
   input  logic [ADDR_WIDTH-1:0] reg_dest_i,
   input  logic                  reg_write_en_i,
   input  logic                  mem_read_i,
   input  logic                  mem_write_i,
   output logic                  dmem_req_o,
   output logic                  dmem_we_o,
   output logic [WORD-1:0]       dmem_addr_o,
   output logic [WORD-1:0]       dmem_wdata_o,
   input  logic                  dmem_ready_i,
   input  logic                  dmem_rvalid_i,
   input  logic [WORD-1:0]       dmem_rdata_i,
   output logic                  reg_write_en_MEM_o,
   output logic [ADDR_WIDTH-1:0] reg_dest_MEM_o,
   output logic [WORD-1:0]       reg_data_MEM_o,
   output logic                  load_pending_o,
   output logic                  reg_write_en_WB_o,
   output logic [ADDR_WIDTH-1:0] reg_dest_WB_o,
   output logic [WORD-1:0]       reg_data_WB_o
);

   // state   | meaning
   // ST_IDLE | slot empty, or holding an ALU-only op that retires this cycle
   // ST_REQ  | load/store request presented on dmem, waiting for dmem_ready_i
   // ST_WAIT | load accepted by memory, waiting for dmem_rvalid_i
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic                  slot_valid_q, slot_valid_d;
   logic                  is_load_q, is_load_d;
   logic                  is_store_q, is_store_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] dest_q, dest_d;
   logic [WORD-1:0]       alu_q, alu_d;
   logic [WORD-1:0]       wdata_q, wdata_d;
   logic                  wb_we_q, wb_we_d;
   logic [ADDR_WIDTH-1:0] wb_dest_q, wb_dest_d;
   logic [WORD-1:0]       wb_data_q, wb_data_d;

   logic alu_only;
   logic req_done;
   logic rsp_done;
   logic complete;
   logic capture;

   assign alu_only = slot_valid_q && (state_q == ST_IDLE);
   assign req_done = (state_q == ST_REQ) && is_store_q && dmem_ready_i;
   assign rsp_done = (state_q == ST_WAIT) && dmem_rvalid_i;
   assign complete = alu_only || req_done || rsp_done;

   // Combinational ready lets a new op enter in the same cycle the current one retires.
   assign ex_ready_o = !slot_valid_q || complete;
   assign capture    = ex_valid_i && ex_ready_o;

   always_comb begin
      state_d = state_q;
      if (capture) begin
         state_d = (mem_read_i || mem_write_i) ? ST_REQ : ST_IDLE;
      end else begin
         unique case (state_q)
            ST_REQ: begin
               if (dmem_ready_i) begin
                  state_d = is_store_q ? ST_IDLE : ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (dmem_rvalid_i) begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      slot_valid_d = slot_valid_q;
      is_load_d    = is_load_q;
      is_store_d   = is_store_q;
      we_d         = we_q;
      dest_d       = dest_q;
      alu_d        = alu_q;
      wdata_d      = wdata_q;
      if (capture) begin
         slot_valid_d = 1'b1;
         is_load_d    = mem_read_i;
         is_store_d   = mem_write_i && !mem_read_i;
         we_d         = reg_write_en_i;
         dest_d       = reg_dest_i;
         alu_d        = alu_result_i;
         wdata_d      = reg_2_data_i;
      end else if (complete) begin
         slot_valid_d = 1'b0;
      end
   end

   // Stores never write the register file, whatever their write-enable says.
   always_comb begin
      wb_we_d   = 1'b0;
      wb_dest_d = wb_dest_q;
      wb_data_d = wb_data_q;
      if (complete && we_q && !is_store_q) begin
         wb_we_d   = 1'b1;
         wb_dest_d = dest_q;
         wb_data_d = is_load_q ? dmem_rdata_i : alu_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= ST_IDLE;
         slot_valid_q <= 1'b0;
         is_load_q    <= 1'b0;
         is_store_q   <= 1'b0;
         we_q         <= 1'b0;
         dest_q       <= '0;
         alu_q        <= '0;
         wdata_q      <= '0;
         wb_we_q      <= 1'b0;
         wb_dest_q    <= '0;
         wb_data_q    <= '0;
      end else begin
         state_q      <= state_d;
         slot_valid_q <= slot_valid_d;
         is_load_q    <= is_load_d;
         is_store_q   <= is_store_d;
         we_q         <= we_d;
         dest_q       <= dest_d;
         alu_q        <= alu_d;
         wdata_q      <= wdata_d;
         wb_we_q      <= wb_we_d;
         wb_dest_q    <= wb_dest_d;
         wb_data_q    <= wb_data_d;
      end
   end

   always_comb begin
      dmem_req_o   = 1'b0;
      dmem_we_o    = 1'b0;
      dmem_addr_o  = '0;
      dmem_wdata_o = '0;
      if (state_q == ST_REQ) begin
         dmem_req_o   = 1'b1;
         dmem_we_o    = is_store_q;
         dmem_addr_o  = alu_q;
         dmem_wdata_o = wdata_q;
      end
   end

   always_comb begin
      reg_write_en_MEM_o = alu_only && we_q;
      reg_dest_MEM_o     = dest_q;
      reg_data_MEM_o     = alu_q;
      load_pending_o     = slot_valid_q && is_load_q;
`ifdef LOAD_EARLY_FORWARD_EN
      if (rsp_done) begin
         reg_write_en_MEM_o = we_q;
         reg_data_MEM_o     = dmem_rdata_i;
         load_pending_o     = 1'b0;
      end
`endif
   end

   assign reg_write_en_WB_o = wb_we_q;
   assign reg_dest_WB_o     = wb_dest_q;
   assign reg_data_WB_o     = wb_data_q;

endmodule

// File: tb/tb_mem_stage_forward_source.sv
// Bench for mem_stage_forward_source: directed vector table, reset sequences, and a randomized
// run checked by transaction-level scoreboards (memory request order, WB retire order).
module tb_mem_stage_forward_source;
`ifdef LOAD_EARLY_FORWARD_EN
   localparam bit EF = 1'b1;
`else
   localparam bit EF = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        ex_valid_i;
   logic        ex_ready_o;
   logic [31:0] alu_result_i;
   logic [31:0] reg_2_data_i;
   logic [3:0]  reg_dest_i;
   logic        reg_write_en_i;
   logic        mem_read_i;
   logic        mem_write_i;
   logic        dmem_req_o;
   logic        dmem_we_o;
   logic [31:0] dmem_addr_o;
   logic [31:0] dmem_wdata_o;
   logic        dmem_ready_i;
   logic        dmem_rvalid_i;
   logic [31:0] dmem_rdata_i;
   logic        reg_write_en_MEM_o;
   logic [3:0]  reg_dest_MEM_o;
   logic [31:0] reg_data_MEM_o;
   logic        load_pending_o;
   logic        reg_write_en_WB_o;
   logic [3:0]  reg_dest_WB_o;
   logic [31:0] reg_data_WB_o;

   mem_stage_forward_source #(.WORD(32), .ADDR_WIDTH(4)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
      .alu_result_i(alu_result_i), .reg_2_data_i(reg_2_data_i), .reg_dest_i(reg_dest_i),
      .reg_write_en_i(reg_write_en_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
      .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
      .dmem_wdata_o(dmem_wdata_o), .dmem_ready_i(dmem_ready_i), .dmem_rvalid_i(dmem_rvalid_i),
      .dmem_rdata_i(dmem_rdata_i),
      .reg_write_en_MEM_o(reg_write_en_MEM_o), .reg_dest_MEM_o(reg_dest_MEM_o),
      .reg_data_MEM_o(reg_data_MEM_o), .load_pending_o(load_pending_o),
      .reg_write_en_WB_o(reg_write_en_WB_o), .reg_dest_WB_o(reg_dest_WB_o),
      .reg_data_WB_o(reg_data_WB_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic        ev;
      logic [31:0] alu;
      logic [31:0] r2;
      logic [3:0]  dest;
      logic        we, rd, wr, rdy, rv;
      logic [31:0] rdata;
   } in_t;

   typedef struct packed {
      logic        ex_ready, req, dwe;
      logic [31:0] addr, wdata;
      logic        mem_we;
      logic [3:0]  mem_dest;
      logic [31:0] mem_data;
      logic        lp, wb_we;
      logic [3:0]  wb_dest;
      logic [31:0] wb_data;
   } exp_t;

   typedef struct packed {
      in_t  i;
      exp_t e;
   } vec_t;

   typedef struct {
      int          kind;    // 0 ALU, 1 load, 2 store
      logic        we;
      logic [3:0]  dest;
      logic [31:0] alu;
      logic [31:0] r2;
   } ins_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mop_t;

   int          n_vec = 0;
   int          n_miss = 0;
   vec_t        vecs[$];
   ins_t        iq[$];
   mop_t        mq[$];
   logic [31:0] ldq[$];
   ins_t        cur;
   bit          pend = 1'b0;
   int          cnt = 0;
   bit          hold = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic in_t vi(logic ev, logic [31:0] alu, logic [31:0] r2, logic [3:0] dest,
                              logic we, logic rd, logic wr, logic rdy, logic rv, logic [31:0] rdata);
      in_t v;
      v.ev = ev; v.alu = alu; v.r2 = r2; v.dest = dest; v.we = we;
      v.rd = rd; v.wr = wr; v.rdy = rdy; v.rv = rv; v.rdata = rdata;
      return v;
   endfunction

   function automatic exp_t ve(logic rdy_o, logic req, logic dwe, logic [31:0] addr, logic [31:0] wdata,
                               logic mwe, logic [3:0] md, logic [31:0] mdata, logic lp,
                               logic wwe, logic [3:0] wd, logic [31:0] wdat);
      exp_t e;
      e.ex_ready = rdy_o; e.req = req; e.dwe = dwe; e.addr = addr; e.wdata = wdata;
      e.mem_we = mwe; e.mem_dest = md; e.mem_data = mdata; e.lp = lp;
      e.wb_we = wwe; e.wb_dest = wd; e.wb_data = wdat;
      return e;
   endfunction

   function automatic exp_t quiet();
      return ve(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endfunction

   function automatic in_t nop();
      return vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endfunction

   task automatic add(input in_t i, input exp_t e);
      vec_t v;
      v.i = i;
      v.e = e;
      vecs.push_back(v);
   endtask

   task automatic drive(input in_t v);
      ex_valid_i     = v.ev;
      alu_result_i   = v.alu;
      reg_2_data_i   = v.r2;
      reg_dest_i     = v.dest;
      reg_write_en_i = v.we;
      mem_read_i     = v.rd;
      mem_write_i    = v.wr;
      dmem_ready_i   = v.rdy;
      dmem_rvalid_i  = v.rv;
      dmem_rdata_i   = v.rdata;
   endtask

   task automatic check_vec(input int n, input exp_t e);
      string t;
      t = $sformatf("vec%0d", n);
      chk({t, ".ex_ready"}, 32'(ex_ready_o), 32'(e.ex_ready));
      chk({t, ".dmem_req"}, 32'(dmem_req_o), 32'(e.req));
      chk({t, ".load_pending"}, 32'(load_pending_o), 32'(e.lp));
      chk({t, ".mem_we"}, 32'(reg_write_en_MEM_o), 32'(e.mem_we));
      chk({t, ".wb_we"}, 32'(reg_write_en_WB_o), 32'(e.wb_we));
      if (e.req) begin
         chk({t, ".dmem_we"}, 32'(dmem_we_o), 32'(e.dwe));
         chk({t, ".dmem_addr"}, dmem_addr_o, e.addr);
         if (e.dwe) chk({t, ".dmem_wdata"}, dmem_wdata_o, e.wdata);
      end
      if (e.mem_we) begin
         chk({t, ".mem_dest"}, 32'(reg_dest_MEM_o), 32'(e.mem_dest));
         chk({t, ".mem_data"}, reg_data_MEM_o, e.mem_data);
      end
      if (e.wb_we) begin
         chk({t, ".wb_dest"}, 32'(reg_dest_WB_o), 32'(e.wb_dest));
         chk({t, ".wb_data"}, reg_data_WB_o, e.wb_data);
      end
   endtask

   task automatic reset_check(input string t);
      chk({t, ".ex_ready"}, 32'(ex_ready_o), 32'd1);
      chk({t, ".dmem_req"}, 32'(dmem_req_o), 32'd0);
      chk({t, ".dmem_we"}, 32'(dmem_we_o), 32'd0);
      chk({t, ".dmem_addr"}, dmem_addr_o, 32'd0);
      chk({t, ".dmem_wdata"}, dmem_wdata_o, 32'd0);
      chk({t, ".mem_we"}, 32'(reg_write_en_MEM_o), 32'd0);
      chk({t, ".mem_dest"}, 32'(reg_dest_MEM_o), 32'd0);
      chk({t, ".mem_data"}, reg_data_MEM_o, 32'd0);
      chk({t, ".load_pending"}, 32'(load_pending_o), 32'd0);
      chk({t, ".wb_we"}, 32'(reg_write_en_WB_o), 32'd0);
      chk({t, ".wb_dest"}, 32'(reg_dest_WB_o), 32'd0);
      chk({t, ".wb_data"}, reg_data_WB_o, 32'd0);
   endtask

   task automatic gen_ins();
      int r;
      r = $urandom_range(0, 19);
      cur.alu  = $urandom;
      cur.r2   = $urandom;
      cur.dest = 4'($urandom_range(0, 15));
      cur.we   = ($urandom_range(0, 3) != 0);
      mem_read_i  = 1'b0;
      mem_write_i = 1'b0;
      if (r < 10) begin
         cur.kind = 0;
      end else if (r < 15) begin
         cur.kind = 1; mem_read_i = 1'b1;
      end else if (r < 19) begin
         cur.kind = 2; mem_write_i = 1'b1; cur.we = 1'b0;
      end else begin
         cur.kind = 1; mem_read_i = 1'b1; mem_write_i = 1'b1;
      end
      ex_valid_i     = 1'b1;
      alu_result_i   = cur.alu;
      reg_2_data_i   = cur.r2;
      reg_dest_i     = cur.dest;
      reg_write_en_i = cur.we;
   endtask

   // Program order is retire order: pop until the next register-writing instruction.
   task automatic check_wb();
      bit          found;
      ins_t        x;
      logic [31:0] d;
      found = 1'b0;
      while (!found && iq.size() > 0) begin
         x = iq.pop_front();
         d = x.alu;
         if (x.kind == 1 && ldq.size() > 0) d = ldq.pop_front();
         if (x.we && x.kind != 2) begin
            found = 1'b1;
            chk("rnd.wb_dest", 32'(reg_dest_WB_o), 32'(x.dest));
            chk("rnd.wb_data", reg_data_WB_o, d);
         end
      end
      if (!found) chk("rnd.wb_unexpected", 32'(reg_write_en_WB_o), 32'd0);
   endtask

   task automatic rnd_cycle(input bit allow_new);
      mop_t m;
      @(negedge clk_i);
      dmem_rvalid_i = 1'b0;
      dmem_rdata_i  = $urandom;
      if (pend) begin
         cnt--;
         if (cnt == 0) begin
            dmem_rvalid_i = 1'b1;
            pend = 1'b0;
            ldq.push_back(dmem_rdata_i);
         end
      end else if ($urandom_range(0, 7) == 0) begin
         dmem_rvalid_i = 1'b1;
      end
      dmem_ready_i = ($urandom_range(0, 2) != 0);
      if (!hold) begin
         if (allow_new && $urandom_range(0, 9) < 7) gen_ins();
         else ex_valid_i = 1'b0;
      end
      #1;
      if (reg_write_en_WB_o) check_wb();
      if (dmem_req_o) begin
         if (mq.size() == 0) begin
            chk("rnd.req_unexpected", 32'(dmem_req_o), 32'd0);
         end else begin
            chk("rnd.dmem_we", 32'(dmem_we_o), 32'(mq[0].we));
            chk("rnd.dmem_addr", dmem_addr_o, mq[0].addr);
            if (mq[0].we) chk("rnd.dmem_wdata", dmem_wdata_o, mq[0].wdata);
            chk("rnd.ex_ready_in_req", 32'(ex_ready_o), 32'(mq[0].we && dmem_ready_i));
            if (dmem_ready_i) begin
               if (!mq[0].we) begin
                  pend = 1'b1;
                  cnt  = $urandom_range(1, 3);
               end
               void'(mq.pop_front());
            end
         end
      end
      if (ex_valid_i && ex_ready_o) begin
         iq.push_back(cur);
         if (cur.kind != 0) begin
            m.we    = (cur.kind == 2);
            m.addr  = cur.alu;
            m.wdata = cur.r2;
            mq.push_back(m);
         end
         hold = 1'b0;
      end else begin
         hold = ex_valid_i;
      end
   endtask

   initial begin
      int rem;
      rst_n_i = 1'b0;
      drive(nop());
      #12;
      reset_check("reset");

      // ALU op to r3
      add(vi(1, 32'h2A, 0, 3, 1, 0, 0, 0, 0, 0), quiet());
      add(nop(), ve(1, 0, 0, 0, 0, 1, 3, 32'h2A, 0, 0, 0, 0));
      add(nop(), ve(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 32'h2A));
      add(nop(), quiet());
      // store with ready low for 2 cycles
      add(vi(1, 32'h100, 32'hDEAD_BEEF, 0, 0, 0, 1, 0, 0, 0), quiet());
      add(nop(), ve(0, 1, 1, 32'h100, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0));
      add(nop(), ve(0, 1, 1, 32'h100, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0));
      add(vi(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), ve(1, 1, 1, 32'h100, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0));
      add(nop(), quiet());
      // load r5, rvalid 2 cycles after accept
      add(vi(1, 32'h200, 0, 5, 1, 1, 0, 0, 0, 0), quiet());
      add(vi(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), ve(0, 1, 0, 32'h200, 0, 0, 0, 0, 1, 0, 0, 0));
      add(nop(), ve(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      add(vi(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1234_5678), ve(1, 0, 0, 0, 0, EF, 5, 32'h1234_5678, !EF, 0, 0, 0));
      add(nop(), ve(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 32'h1234_5678));
      add(nop(), quiet());
      // back-to-back ALU ops r1, r2
      add(vi(1, 32'h11, 0, 1, 1, 0, 0, 0, 0, 0), quiet());
      add(vi(1, 32'h22, 0, 2, 1, 0, 0, 0, 0, 0), ve(1, 0, 0, 0, 0, 1, 1, 32'h11, 0, 0, 0, 0));
      add(nop(), ve(1, 0, 0, 0, 0, 1, 2, 32'h22, 0, 1, 1, 32'h11));
      add(nop(), ve(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 32'h22));
      add(nop(), quiet());
      // zero-wait load r7 = 0xCAFE, in WB three cycles after presentation
      add(vi(1, 32'h300, 0, 7, 1, 1, 0, 0, 0, 0), quiet());
      add(vi(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), ve(0, 1, 0, 32'h300, 0, 0, 0, 0, 1, 0, 0, 0));
      add(vi(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFE), ve(1, 0, 0, 0, 0, EF, 7, 32'hCAFE, !EF, 0, 0, 0));
      add(nop(), ve(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 32'hCAFE));
      // ALU op without write-enable
      add(vi(1, 32'h55, 0, 4, 0, 0, 0, 0, 0, 0), quiet());
      add(nop(), quiet());
      add(nop(), quiet());
      // read+write together behaves as a load
      add(vi(1, 32'h400, 32'h99, 6, 1, 1, 1, 0, 0, 0), quiet());
      add(vi(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), ve(0, 1, 0, 32'h400, 0, 0, 0, 0, 1, 0, 0, 0));
      add(vi(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hAB), ve(1, 0, 0, 0, 0, EF, 6, 32'hAB, !EF, 0, 0, 0));
      add(nop(), ve(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 32'hAB));
      // rvalid with nothing outstanding
      add(vi(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h77), quiet());
      add(nop(), quiet());

      @(negedge clk_i);
      rst_n_i = 1'b1;
      foreach (vecs[k]) begin
         @(negedge clk_i);
         drive(vecs[k].i);
         #1;
         check_vec(k, vecs[k].e);
      end

      // reset while a request is on the bus
      @(negedge clk_i);
      drive(vi(1, 32'h500, 0, 9, 1, 1, 0, 0, 0, 0));
      @(negedge clk_i);
      drive(nop());
      #1;
      chk("rstreq.pre_req", 32'(dmem_req_o), 32'd1);
      #2;
      rst_n_i = 1'b0;
      #1;
      reset_check("rstreq");
      @(negedge clk_i);
      rst_n_i = 1'b1;
      #1;
      reset_check("rstreq.release");

      // reset in WAIT, then a stale rvalid
      @(negedge clk_i);
      drive(vi(1, 32'h600, 0, 10, 1, 1, 0, 0, 0, 0));
      @(negedge clk_i);
      drive(vi(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      #1;
      chk("rstwait.req", 32'(dmem_req_o), 32'd1);
      @(negedge clk_i);
      drive(nop());
      #1;
      chk("rstwait.pending", 32'(load_pending_o), 32'd1);
      #2;
      rst_n_i = 1'b0;
      #1;
      reset_check("rstwait");
      @(negedge clk_i);
      rst_n_i = 1'b1;
      drive(vi(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hBAD));
      #1;
      reset_check("rstwait.stale");
      @(negedge clk_i);
      drive(nop());
      #1;
      reset_check("rstwait.after");

      // randomized run against the scoreboards
      @(negedge clk_i);
      rst_n_i = 1'b0;
      drive(nop());
      @(negedge clk_i);
      rst_n_i = 1'b1;
      for (int c = 0; c < 3000; c++) rnd_cycle(1'b1);
      for (int c = 0; c < 200; c++) rnd_cycle(1'b0);
      rem = 0;
      foreach (iq[k]) if (iq[k].we && iq[k].kind != 2) rem++;
      chk("rnd.unretired_writes", 32'(rem), 32'd0);
      chk("rnd.unissued_requests", 32'(mq.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
